fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage, directly upstream of the IF/ID pipeline register. Owns the architectural PC and drives the instruction-cache read port. Handles variable-latency cache misses, hazard stalls, branch/jump redirects and HALT. Produces the next-PC (PC+2), the fetched instruction and an instruction-stall flag. These feed the IF/ID register's pc_in, instr_in and istall_in.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, encoding injected when no valid instruction is available.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
stall_in  input  1  hazard-unit stall; IF/ID write enable is its inverse
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_pc  input  16  redirect target; bit 0 ignored (forced 0)
halt_in  input  1  HALT decoded; stop fetching
imem_rdata  input  16  cache read data, valid when imem_done=1
imem_done  input  1  cache read complete this cycle (hit same cycle, miss later)
imem_addr  output  16  cache read address
imem_rd  output  1  cache read request
pc_out  output  16  current fetch PC
pc_plus2_out  output  16  pc_out+2, to IF/ID pc_in
instr_out  output  16  instruction to IF/ID instr_in
istall_out  output  1  1 = instr_out is an injected NOP, to IF/ID istall_in
halted_out  output  1  1 = fetch permanently stopped

Behaviour:
- Registers: pc[15:0], state {RUN, MISS, DRAIN, HALTED}, hold_instr[15:0], hold_valid, tgt[15:0], halt_pend.
- Reset (rst=0, async) sets pc=RESET_PC, state=RUN, hold_valid=0, halt_pend=0, tgt=0.
  - Outputs immediately after reset: pc_out=RESET_PC, pc_plus2_out=RESET_PC+2, imem_rd=1, imem_addr=RESET_PC, halted_out=0.
  - instr_out=NOP_INSTR and istall_out=1 until imem_done.
  - Reset mid-miss abandons the miss. The cache is reset by the same rst.
- imem_addr=pc always. imem_rd=1 in RUN with hold_valid=0, and in MISS and DRAIN. imem_rd=0 in HALTED or when hold_valid=1. imem_addr and imem_rd stay stable until imem_done.
- pc_plus2_out=pc+2, modulo 2^16 (16'hFFFE -> 16'h0000).
- Instruction select (combinational):
  - hold_valid=1: instr_out=hold_instr, istall_out=0.
  - else RUN with imem_done=1: instr_out=imem_rdata, istall_out=0.
  - otherwise: instr_out=NOP_INSTR, istall_out=1.
- Priority, highest first: redirect, then halt, then stall, then advance.
- RUN:
  - redirect_valid=1: pc<=redirect_pc&~1, hold_valid<=0. If imem_done=0 (miss in flight), tgt<=target, go DRAIN, pc unchanged.
  - halt_in=1 with imem_done=1 or hold_valid=1: go HALTED.
  - halt_in=1 with imem_done=0 and hold_valid=0: halt_pend<=1, go MISS.
  - imem_done=0 and hold_valid=0: go MISS.
  - valid instr and stall_in=1: if imem_done=1 and hold_valid=0, latch hold_instr<=imem_rdata, hold_valid<=1. pc held.
  - valid instr and stall_in=0: pc<=pc+2, hold_valid<=0.
- MISS: outputs NOP/istall=1.
  - imem_done=1: go RUN; if halt_pend=1, go HALTED instead.
  - The completing cycle's data is not consumed. RUN re-reads the line, now a hit.
  - redirect_valid=1: tgt<=target, go DRAIN.
  - halt_in=1 latches halt_pend.
- DRAIN: outputs NOP/istall=1; returned data is discarded.
  - A further redirect overwrites tgt (the latest wins).
  - imem_done=1: pc<=tgt, go RUN.
  - halt_pend is cleared on entering DRAIN; the redirect squashes the halting instruction.
- HALTED: imem_rd=0, NOP/istall=1, halted_out=1, pc frozen. Exit only by reset.
- Simultaneous imem_done and redirect in RUN: redirect wins; the fetched instruction is dropped.
- stall_in ignored in MISS, DRAIN and HALTED.

Test Plan:
- Reset, always-hit cache (done same cycle), rdata=16'h1234: after rst release, cycle 0 gives pc_out=0000, instr_out=1234, istall_out=0; next cycle pc_out=0002, pc_plus2_out=0004.
- Miss at pc=0x0010 with done after 4 cycles: 4 cycles of instr_out=0800, istall_out=1, pc held 0x0010; then a re-read hit and pc advances to 0x0012.
- Hit with stall_in=1 for 3 cycles, rdata changing afterwards: instr_out stays the latched value, imem_rd=0, pc held. On stall release pc advances once.
- Redirect to 16'h0041 during miss: DRAIN, returned data discarded, istall_out=1. After done, pc_out=0x0040, and the first non-NOP instr is from 0x0040.
- Redirect plus stall_in=1 in the same RUN cycle: pc<=redirect target, hold_valid cleared.
- pc=16'hFFFE advances to 16'h0000. halt_in during a miss: halted_out=1 after done, imem_rd=0 thereafter. rst low mid-miss restores pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage that owns the PC and drives the
//               I-cache read port. It handles misses, stalls, redirects and
//               HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2_out,
    output logic [15:0] instr_out,
    output logic        istall_out,
    output logic        halted_out
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic [15:0] hold_instr;
    logic [15:0] hold_instr_nxt;
    logic        hold_valid;
    logic        hold_valid_nxt;
    logic [15:0] tgt;
    logic [15:0] tgt_nxt;
    logic        halt_pend;
    logic        halt_pend_nxt;

    logic [15:0] redirect_tgt;
    logic        instr_ok;

    assign redirect_tgt = {redirect_pc[15:1], 1'b0};
    // An instruction is available in RUN either from the hold buffer or a hit.
    assign instr_ok     = hold_valid | imem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            hold_instr <= 16'h0000;
            hold_valid <= 1'b0;
            tgt        <= 16'h0000;
            halt_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_instr <= hold_instr_nxt;
            hold_valid <= hold_valid_nxt;
            tgt        <= tgt_nxt;
            halt_pend  <= halt_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_instr_nxt = hold_instr;
        hold_valid_nxt = hold_valid;
        tgt_nxt        = tgt;
        halt_pend_nxt  = halt_pend;

        case (state)
            RUN: begin
                if (redirect_valid) begin
                    hold_valid_nxt = 1'b0;
                    // A read still in flight must complete before the new PC is used.
                    if (!imem_done && !hold_valid) begin
                        tgt_nxt       = redirect_tgt;
                        halt_pend_nxt = 1'b0;
                        state_nxt     = DRAIN;
                    end else begin
                        pc_nxt = redirect_tgt;
                    end
                end else if (halt_in) begin
                    if (instr_ok) begin
                        hold_valid_nxt = 1'b0;
                        state_nxt      = HALTED;
                    end else begin
                        halt_pend_nxt = 1'b1;
                        state_nxt     = MISS;
                    end
                end else if (!instr_ok) begin
                    state_nxt = MISS;
                end else if (stall_in) begin
                    if (!hold_valid) begin
                        hold_instr_nxt = imem_rdata;
                        hold_valid_nxt = 1'b1;
                    end
                end else begin
                    pc_nxt         = pc + 16'd2;
                    hold_valid_nxt = 1'b0;
                end
            end

            MISS: begin
                if (redirect_valid) begin
                    tgt_nxt       = redirect_tgt;
                    halt_pend_nxt = 1'b0;
                    state_nxt     = DRAIN;
                end else if (imem_done) begin
                    // Completion data is dropped; RUN re-reads the now-resident line.
                    halt_pend_nxt = 1'b0;
                    state_nxt     = (halt_pend || halt_in) ? HALTED : RUN;
                end else if (halt_in) begin
                    halt_pend_nxt = 1'b1;
                end
            end

            DRAIN: begin
                if (imem_done) begin
                    pc_nxt    = redirect_valid ? redirect_tgt : tgt;
                    state_nxt = RUN;
                end else if (redirect_valid) begin
                    tgt_nxt = redirect_tgt;
                end
            end

            default: begin
                state_nxt = HALTED;
            end
        endcase
    end

    always_comb begin
        imem_addr    = pc;
        pc_out       = pc;
        pc_plus2_out = pc + 16'd2;
        halted_out   = (state == HALTED);
        imem_rd      = 1'b0;
        instr_out    = NOP_INSTR;
        istall_out   = 1'b1;

        case (state)
            RUN:     imem_rd = !hold_valid;
            MISS:    imem_rd = 1'b1;
            DRAIN:   imem_rd = 1'b1;
            default: imem_rd = 1'b0;
        endcase

        if (state == RUN && hold_valid) begin
            instr_out  = hold_instr;
            istall_out = 1'b0;
        end else if (state == RUN && imem_done) begin
            instr_out  = imem_rdata;
            istall_out = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed vector bench for fetch_stage; the bench itself drives
//               the cache response signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_in;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2_out;
    logic [15:0] instr_out;
    logic        istall_out;
    logic        halted_out;

    int tests;
    int failed;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_in       (halt_in),
        .imem_rdata    (imem_rdata),
        .imem_done     (imem_done),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .pc_out        (pc_out),
        .pc_plus2_out  (pc_plus2_out),
        .instr_out     (instr_out),
        .istall_out    (istall_out),
        .halted_out    (halted_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        halt;
        logic        done;
        logic [15:0] rdata;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic [15:0] instr;
        logic        istall;
        logic        rd;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv,
                                input logic [15:0] rpc, input logic h,
                                input logic d, input logic [15:0] rdata,
                                input logic [15:0] pc, input logic [15:0] pc2,
                                input logic [15:0] instr, input logic ist,
                                input logic rd, input logic hl);
        vec_t v;
        v.rst = r;   v.stall = s;  v.redir = rv; v.rpc = rpc;
        v.halt = h;  v.done = d;   v.rdata = rdata;
        v.pc = pc;   v.pc2 = pc2;  v.instr = instr;
        v.istall = ist; v.rd = rd; v.halted = hl;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] epc,
                         input logic [15:0] ep2, input logic [15:0] ein,
                         input logic eist, input logic erd, input logic ehl);
        tests++;
        if (pc_out !== epc || pc_plus2_out !== ep2 || imem_addr !== epc ||
            instr_out !== ein || istall_out !== eist || imem_rd !== erd ||
            halted_out !== ehl) begin
            failed++;
            $display("FAIL %s: got pc=%h pc2=%h addr=%h instr=%h istall=%b rd=%b halted=%b ; want pc=%h pc2=%h addr=%h instr=%h istall=%b rd=%b halted=%b",
                     name, pc_out, pc_plus2_out, imem_addr, instr_out, istall_out,
                     imem_rd, halted_out, epc, ep2, epc, ein, eist, erd, ehl);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv,
                         input logic [15:0] rpc, input logic h, input logic d,
                         input logic [15:0] rdata);
        rst = r; stall_in = s; redirect_valid = rv; redirect_pc = rpc;
        halt_in = h; imem_done = d; imem_rdata = rdata;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        //               rst st rv rpc       hl dn rdata     pc        pc2       instr     ist rd hl
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'h0000, 16'h0002, 16'h1234, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0002, 16'h0004, 16'h5678, 0, 1, 0));
        // Stall on a hit: latched word held while cache data changes.
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'hAAAA, 16'h0004, 16'h0006, 16'hAAAA, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'hBBBB, 16'h0004, 16'h0006, 16'hAAAA, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'hCCCC, 16'h0004, 16'h0006, 16'hAAAA, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDDDD, 16'h0004, 16'h0006, 16'hAAAA, 0, 0, 0));
        // Miss at 0x0006, completion data dropped, then re-read hit.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0006, 16'h0008, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0006, 16'h0008, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0006, 16'h0008, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hEEEE, 16'h0006, 16'h0008, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0006, 16'h0008, 16'h1111, 0, 1, 0));
        // Redirect + stall in the same RUN cycle.
        vecs.push_back(mk(1, 1, 1, 16'h0010, 0, 1, 16'h2222, 16'h0008, 16'h000A, 16'h2222, 0, 1, 0));
        // Miss at 0x0010 with done on the fourth cycle.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0012, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0012, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0012, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h3030, 16'h0010, 16'h0012, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h3333, 16'h0010, 16'h0012, 16'h3333, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h4444, 16'h0012, 16'h0014, 16'h4444, 0, 1, 0));
        // Redirect to 0x0041 during a miss: drain, then fetch from 0x0040.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0014, 16'h0016, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0041, 0, 0, 16'h0000, 16'h0014, 16'h0016, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0014, 16'h0016, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h5555, 16'h0014, 16'h0016, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h6666, 16'h0040, 16'h0042, 16'h6666, 0, 1, 0));
        // Redirect with read in flight, overwritten in DRAIN (stall ignored), wrap at FFFE.
        vecs.push_back(mk(1, 0, 1, 16'h0100, 0, 0, 16'h0000, 16'h0042, 16'h0044, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0042, 16'h0044, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h7777, 16'h0042, 16'h0044, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h8888, 16'hFFFE, 16'h0000, 16'h8888, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h9999, 16'h0000, 16'h0002, 16'h9999, 0, 1, 0));
        // HALT during a miss: halts once done arrives; redirect then ignored.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0002, 16'h0004, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h0004, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hABCD, 16'h0002, 16'h0004, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h0004, 16'h0800, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 16'h0200, 0, 1, 16'h1234, 16'h0002, 16'h0004, 16'h0800, 1, 0, 1));
        // Reset, redirect on a hit, then reset in the middle of a miss.
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0002, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0300, 0, 1, 16'h0001, 16'h0000, 16'h0002, 16'h0001, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0300, 16'h0302, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0300, 16'h0302, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0002, 16'h0800, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h4321, 16'h0000, 16'h0002, 16'h4321, 0, 1, 0));
        // HALT on a hit stops immediately.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h5A5A, 16'h0002, 16'h0004, 16'h5A5A, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h0004, 16'h0800, 1, 0, 1));

        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check("reset", 16'h0000, 16'h0002, 16'h0800, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].halt, vecs[i].done, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pc2, vecs[i].instr,
                  vecs[i].istall, vecs[i].rd, vecs[i].halted);
        end

        // HALT while a stalled instruction is held in the buffer.
        @(negedge clk);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check("halt_hold_reset", 16'h0000, 16'h0002, 16'h0800, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1, 0, 16'h0000, 0, 1, 16'hC0DE);
        #1;
        check("halt_hold_latch", 16'h0000, 16'h0002, 16'hC0DE, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1, 0, 16'h0000, 1, 0, 16'h0000);
        #1;
        check("halt_hold_req", 16'h0000, 16'h0002, 16'hC0DE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check("halt_hold_halted", 16'h0000, 16'h0002, 16'h0800, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
